count_ctrl: RTL and testbench

COUNT_CTRL -- requirements
Module: count_ctrl

---
 rtl/count_ctrl_pkg.sv | 13 +
 rtl/count_ctrl_presc.sv | 28 ++
 rtl/count_ctrl.sv | 131 +++++++++++++
 tb/tb_count_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/count_ctrl_pkg.sv
// Shared types for the count_ctrl terminal counter: FSM state encoding and mode constants.
package count_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

    localparam logic ONESHOT  = 1'b0;
    localparam logic PERIODIC = 1'b1;

endpackage

// File: rtl/count_ctrl_presc.sv
// Tick prescaler for count_ctrl: pulses tick once every (div+1) enabled cycles.
module count_ctrl_presc #(
    parameter int PRESC_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   en,
    input  logic [PRESC_WIDTH-1:0] div,
    output logic                   tick
);

    localparam logic [PRESC_WIDTH-1:0] ONE = PRESC_WIDTH'(1);

    logic [PRESC_WIDTH-1:0] cnt_q;

    // Tick is combinational so the counter consumes it on the same edge the prescaler wraps.
    assign tick = en && (cnt_q == div);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= (cnt_q == div) ? '0 : cnt_q + ONE;
        end
    end

endmodule

// File: rtl/count_ctrl.sv
// Start/stop/pause terminal counter with one-shot and periodic modes.
// Optional tick prescaler is enabled by defining COUNT_CTRL_PRESCALE_EN.
import count_ctrl_pkg::*;

module count_ctrl #(
    parameter int WIDTH       = 8,
    parameter int PRESC_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   pause,
    input  logic                   mode,
    input  logic [WIDTH-1:0]       load_val,
    input  logic [PRESC_WIDTH-1:0] presc_div,
    output logic [WIDTH-1:0]       count,
    output logic                   busy,
    output logic                   done,
    output state_t                 state_o
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] tc_q, tc_d;
    logic             mode_q, mode_d;
    logic             done_q, done_d;

    logic start_ok;
    logic run_en;
    logic tick;

    assign start_ok = (state_q == IDLE) && start && (load_val != '0);
    // Counting is allowed on any busy edge where neither stop nor pause wins priority.
    assign run_en   = (state_q != IDLE) && !stop && !pause;

`ifdef COUNT_CTRL_PRESCALE_EN
    logic [PRESC_WIDTH-1:0] div_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
        end else if (start_ok) begin
            div_q <= presc_div;
        end
    end

    count_ctrl_presc #(
        .PRESC_WIDTH(PRESC_WIDTH)
    ) u_presc (
        .clk  (clk),
        .rst  (rst),
        .clr  (start_ok || stop),
        .en   (run_en),
        .div  (div_q),
        .tick (tick)
    );
`else
    logic unused_presc;
    assign unused_presc = ^presc_div;
    assign tick         = run_en;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            tc_q    <= '0;
            mode_q  <= ONESHOT;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tc_q    <= tc_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    // The edge that leaves PAUSED also counts, so a pause of N cycles delays completion by N.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tc_d    = tc_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                count_d = '0;
                if (start_ok) begin
                    tc_d    = load_val;
                    mode_d  = mode;
                    state_d = RUN;
                end
            end
            RUN, PAUSED: begin
                if (stop) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (pause) begin
                    state_d = PAUSED;
                end else begin
                    state_d = RUN;
                    if (tick) begin
                        if (count_q == tc_q) begin
                            count_d = '0;
                            done_d  = 1'b1;
                            if (mode_q == ONESHOT) begin
                                state_d = IDLE;
                            end
                        end else begin
                            count_d = count_q + ONE;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    assign count   = count_q;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_count_ctrl.sv
// Directed self-checking bench for count_ctrl: reset, one-shot, periodic, pause, stop, reset abort.
module tb_count_ctrl;
    import count_ctrl_pkg::*;

    localparam int WIDTH       = 8;
    localparam int PRESC_WIDTH = 4;

    logic                   clk;
    logic                   rst;
    logic                   start;
    logic                   stop;
    logic                   pause;
    logic                   mode;
    logic [WIDTH-1:0]       load_val;
    logic [PRESC_WIDTH-1:0] presc_div;
    logic [WIDTH-1:0]       count;
    logic                   busy;
    logic                   done;
    state_t                 state_o;

    int n_tests = 0;
    int n_fail  = 0;

    count_ctrl #(
        .WIDTH       (WIDTH),
        .PRESC_WIDTH (PRESC_WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .pause     (pause),
        .mode      (mode),
        .load_val  (load_val),
        .presc_div (presc_div),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .state_o   (state_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int c, input logic b, input logic d);
        chk({tag, "/count"}, count, c);
        chk({tag, "/busy"}, busy, b);
        chk({tag, "/done"}, done, d);
    endtask

    task automatic do_start(input logic m, input int tc);
        start    = 1'b1;
        mode     = m;
        load_val = tc[WIDTH-1:0];
        step();
        start    = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        pause     = 1'b0;
        mode      = 1'b0;
        load_val  = '0;
        presc_div = '0;
        step();
        step();
        rst = 1'b0;
        expect_out("reset", 0, 1'b0, 1'b0);
        chk("reset/state", state_o, IDLE);

        // One-shot, TC=3: count 0,1,2,3 then 0 with done and busy dropping together.
        do_start(ONESHOT, 3);
        expect_out("os_e0", 0, 1'b1, 1'b0);
        chk("os_e0/state", state_o, RUN);
        step(); expect_out("os_e1", 1, 1'b1, 1'b0);
        step(); expect_out("os_e2", 2, 1'b1, 1'b0);
        step(); expect_out("os_e3", 3, 1'b1, 1'b0);
        step(); expect_out("os_e4", 0, 1'b0, 1'b1);
        step(); expect_out("os_e5", 0, 1'b0, 1'b0);

        // Periodic, TC=2, with config changes and a start request while busy.
        do_start(PERIODIC, 2);
        expect_out("per_e0", 0, 1'b1, 1'b0);
        step(); expect_out("per_e1", 1, 1'b1, 1'b0);
        step(); expect_out("per_e2", 2, 1'b1, 1'b0);
        step(); expect_out("per_e3", 0, 1'b1, 1'b1);
        start    = 1'b1;
        load_val = 8'd7;
        mode     = ONESHOT;
        step(); expect_out("per_e4", 1, 1'b1, 1'b0);
        start = 1'b0;
        step(); expect_out("per_e5", 2, 1'b1, 1'b0);
        step(); expect_out("per_e6", 0, 1'b1, 1'b1);
        step(); expect_out("per_e7", 1, 1'b1, 1'b0);
        stop = 1'b1;
        step(); expect_out("per_stop", 0, 1'b0, 1'b0);
        stop = 1'b0;
        step(); expect_out("per_after1", 0, 1'b0, 1'b0);
        step(); expect_out("per_after2", 0, 1'b0, 1'b0);

        // Pause for three edges while count is 2 on a one-shot TC=5.
        do_start(ONESHOT, 5);
        step(); expect_out("pz_e1", 1, 1'b1, 1'b0);
        step(); expect_out("pz_e2", 2, 1'b1, 1'b0);
        pause = 1'b1;
        step(); expect_out("pz_e3", 2, 1'b1, 1'b0);
        chk("pz_e3/state", state_o, PAUSED);
        step(); expect_out("pz_e4", 2, 1'b1, 1'b0);
        step(); expect_out("pz_e5", 2, 1'b1, 1'b0);
        pause = 1'b0;
        step(); expect_out("pz_e6", 3, 1'b1, 1'b0);
        chk("pz_e6/state", state_o, RUN);
        step(); expect_out("pz_e7", 4, 1'b1, 1'b0);
        step(); expect_out("pz_e8", 5, 1'b1, 1'b0);
        step(); expect_out("pz_e9", 0, 1'b0, 1'b1);

        // Stop on the same edge as a terminal tick suppresses done.
        do_start(PERIODIC, 1);
        step(); expect_out("st_e1", 1, 1'b1, 1'b0);
        stop = 1'b1;
        step(); expect_out("st_term", 0, 1'b0, 1'b0);
        stop = 1'b0;

        // Zero terminal value is not a valid start.
        do_start(ONESHOT, 0);
        expect_out("zero_e0", 0, 1'b0, 1'b0);
        step(); expect_out("zero_e1", 0, 1'b0, 1'b0);

        // Stop while paused.
        do_start(ONESHOT, 4);
        pause = 1'b1;
        step(); expect_out("sp_pause", 0, 1'b1, 1'b0);
        stop = 1'b1;
        step(); expect_out("sp_stop", 0, 1'b0, 1'b0);
        stop  = 1'b0;
        pause = 1'b0;

        // Reset at count=4 of TC=10 aborts silently; start honoured straight after.
        do_start(ONESHOT, 10);
        step(); step(); step(); step();
        expect_out("rs_c4", 4, 1'b1, 1'b0);
        rst = 1'b1;
        step(); expect_out("rs_hit", 0, 1'b0, 1'b0);
        chk("rs_hit/state", state_o, IDLE);
        rst = 1'b0;
        do_start(ONESHOT, 1);
        expect_out("rs_restart", 0, 1'b1, 1'b0);
        step(); expect_out("rs_r1", 1, 1'b1, 1'b0);
        step(); expect_out("rs_r2", 0, 1'b0, 1'b1);

`ifdef COUNT_CTRL_PRESCALE_EN
        // Divisor 2 gives a tick every third RUN cycle.
        presc_div = 4'd2;
        do_start(ONESHOT, 1);
        presc_div = 4'd0;
        expect_out("pre_e0", 0, 1'b1, 1'b0);
        step(); expect_out("pre_e1", 0, 1'b1, 1'b0);
        step(); expect_out("pre_e2", 0, 1'b1, 1'b0);
        step(); expect_out("pre_e3", 1, 1'b1, 1'b0);
        step(); expect_out("pre_e4", 1, 1'b1, 1'b0);
        step(); expect_out("pre_e5", 1, 1'b1, 1'b0);
        step(); expect_out("pre_e6", 0, 1'b0, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
